// File: rtl/piso_serializer_8.sv
// -----------------------------------------------------------------------------
// piso_serializer_8
//
// Parallel-in / serial-out converter with valid/ready handshakes on both
// sides. A parallel word is accepted on in_valid && in_ready, then shifted
// out one bit per ser_valid && ser_ready transfer. A new word can be accepted
// during the final bit transfer so back-to-back words stream without a gap.
//
// Parameters
//   WIDTH      parallel word width in bits
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   in_data    parallel word from upstream
//   in_valid   in_data is valid
//   in_ready   word is accepted this cycle (combinational, forced 0 in reset)
//   ser_ready  downstream consumes ser_out this cycle
//   ser_out    current serial bit
//   ser_valid  ser_out holds a valid bit
//   ser_last   ser_out is the final bit of the current word
//   busy       a word is held or being shifted
//
// States
//   state | meaning
//   IDLE  | no word held; in_ready=1, serial outputs low
//   SHIFT | word held; ser_out presents the next bit, counter = bits left - 1
// -----------------------------------------------------------------------------
module piso_serializer_8 #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;

  logic             xfer;
  logic             last_xfer;
  logic             accept;
  logic [WIDTH-1:0] shreg_shifted;

  // A bit moves downstream whenever a word is held and the sink is ready.
  assign xfer      = (state_q == SHIFT) && ser_ready;
  assign last_xfer = xfer && (cnt_q == '0);

  // in_ready depends on ser_ready so that the next word can be taken during
  // the final bit transfer; it is held low while reset is asserted.
  assign in_ready  = reset && ((state_q == IDLE) || last_xfer);
  assign accept    = in_valid && in_ready;

  // Shift toward the output end, filling with zero.
  assign shreg_shifted = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = in_data;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (cnt_q != '0) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q - CW'(1);
          end else if (accept) begin
            shreg_d = in_data;
            cnt_d   = CNT_LOAD;
          end else begin
            // Clear the register on the way out so no stale bits linger.
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are computed from next state so they come straight off flops and
  // line up with the state they describe.
  always_comb begin
    ser_valid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT);
    ser_last_d  = (state_d == SHIFT) && (cnt_d == '0);
    ser_out_d   = (state_d == SHIFT) && shreg_d[OUT_IDX];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;

endmodule

// File: doc/piso_serializer_8.md
PISO_SERIALIZER_8 -- requirements
Module: piso_serializer_8

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 in_data  input  WIDTH  parallel word from the upstream register.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 ser_ready  input  1  downstream consumes ser_out this cycle.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 ser_valid  output  1  ser_out holds a valid bit.
REQ-011 ser_last  output  1  ser_out is the final bit of the current word.
REQ-012 busy  output  1  a word is held or being shifted.

Function
REQ-013 FSM states: IDLE and SHIFT, with a WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 IDLE: in_ready=1, ser_valid=0, ser_last=0, ser_out=0, busy=0.
REQ-015 Accept = in_valid && in_ready at a rising edge; on accept, load the shift register with in_data, set counter=WIDTH-1, and enter SHIFT.
REQ-016 Latency: the first bit appears on ser_out with ser_valid=1 in the cycle after accept.
REQ-017 SHIFT: ser_valid=1, busy=1; ser_out = shreg[WIDTH-1] if MSB_FIRST=1, else shreg[0].
REQ-018 Bit transfer = ser_valid && ser_ready; on transfer with counter>0, shift by one toward the output end, fill with 0, and decrement counter.
REQ-019 Stall: when ser_ready=0 in SHIFT, ser_out, ser_last, the counter and the shift register hold unchanged.
REQ-020 ser_last = 1 exactly when in SHIFT with counter==0.
REQ-021 in_ready in SHIFT = ser_last && ser_ready (back-to-back accept during the final bit transfer); otherwise 0.
REQ-022 Final bit transfer with in_valid=1: load the new word, set counter=WIDTH-1, stay in SHIFT; no idle bubble.
REQ-023 Final bit transfer with in_valid=0: return to IDLE.
REQ-024 in_data changes while not accepted have no effect; the loaded word is never altered mid-shift.
REQ-025 Exactly WIDTH transfers occur per accepted word, in order, with no bits lost or duplicated under any ser_ready pattern.

Reset
REQ-026 reset=0 asynchronously forces IDLE, shift register=0, counter=0, ser_out=0, ser_valid=0, ser_last=0, busy=0, and in_ready=0 while reset is asserted.
REQ-027 Reset asserted mid-word discards the word; after release the block is in IDLE with in_ready=1 on the first clock edge.
REQ-028 No output toggles other than to its reset value while reset=0.

Verification
REQ-029 Basic MSB-first: WIDTH=8, accept 0xA5, ser_ready=1 constantly -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after accept; ser_last only on the 8th bit; then IDLE.
REQ-030 LSB-first: MSB_FIRST=0, accept 0x01 -> ser_out 1 then seven 0s; ser_last on the 8th bit.
REQ-031 Stall: accept 0xF0, toggle ser_ready 1,0,0,1,... -> ser_out holds during the 0 cycles; the sequence is still 1,1,1,1,0,0,0,0 with 8 transfers total.
REQ-032 Back-to-back: in_valid held high with 0x3C then 0xC3 -> 16 contiguous valid bits; the second accept coincides with the first word's ser_last transfer; no ser_valid=0 gap.
REQ-033 Reset mid-operation: accept 0xFF, assert reset after 3 transfers -> all outputs 0 immediately; after release, accept 0x81 -> output 1,0,0,0,0,0,0,1 with no residue from 0xFF.
REQ-034 Idle noise: in_data toggling while in_valid=0 -> ser_valid stays 0 and busy stays 0.
